// File: rtl/cache_block_arbiter.sv
// ---------------------------------------------------------------------------
// cache_block_arbiter
//
// Purpose: two-requester arbiter and sequencer for a single cache_block array
// of NUM_OF_ENTRY words. Each transaction walks IDLE -> ACCESS -> DONE. The
// winner's index, write enable and data are latched in IDLE. The array is
// driven for exactly one ACCESS cycle. The winner's done pulses for one cycle
// in DONE.
//
// Configuration macro:
//   CACHE_ARB_RR_EN  defined     -> round-robin tie-break (port 0 wins the
//                                   first tie after reset).
//                    not defined -> fixed priority; port 0 always wins ties
//                                   and no pointer register is built.
//
// Ports:
//   clk_i               system clock, rising edge
//   rst_i               asynchronous active-high reset
//   req0_i / req1_i     request level per requester
//   we0_i  / we1_i      1 = write, 0 = read (sampled with req)
//   index0_i / index1_i target entry
//   din0_i / din1_i     write data
//   gnt0_o / gnt1_o     port owns the array (ACCESS and DONE)
//   done0_o / done1_o   one-cycle completion pulse
//   rdata0_o / rdata1_o last read result per port, held between reads
//   cb_index_o          to cache_block.index
//   cb_we_o             to cache_block.we
//   cb_din_o            to cache_block.din
//   cb_dout_i           from cache_block.dout (combinational read)
// ---------------------------------------------------------------------------
module cache_block_arbiter #(
    parameter int NUM_OF_ENTRY = 1024,
    parameter int ENTRY_WIDTH  = 10,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req0_i,
    input  logic                   req1_i,
    input  logic                   we0_i,
    input  logic                   we1_i,
    input  logic [ENTRY_WIDTH-1:0] index0_i,
    input  logic [ENTRY_WIDTH-1:0] index1_i,
    input  logic [DATA_WIDTH-1:0]  din0_i,
    input  logic [DATA_WIDTH-1:0]  din1_i,
    output logic                   gnt0_o,
    output logic                   gnt1_o,
    output logic                   done0_o,
    output logic                   done1_o,
    output logic [DATA_WIDTH-1:0]  rdata0_o,
    output logic [DATA_WIDTH-1:0]  rdata1_o,
    output logic [ENTRY_WIDTH-1:0] cb_index_o,
    output logic                   cb_we_o,
    output logic [DATA_WIDTH-1:0]  cb_din_o,
    input  logic [DATA_WIDTH-1:0]  cb_dout_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;   // 0 = port 0, 1 = port 1
    logic                    wr_q, wr_d;         // latched transaction type
    logic                    cb_we_q, cb_we_d;
    logic [ENTRY_WIDTH-1:0]  index_q, index_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;

    // Winner selection and the winner's request fields
    logic                    pick;
    logic                    win_we;
    logic [ENTRY_WIDTH-1:0]  win_index;
    logic [DATA_WIDTH-1:0]   win_din;
    logic                    win_in_range;

`ifdef CACHE_ARB_RR_EN
    // Pointer holds the port served last; on a tie the other port wins.
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (state_q == ST_DONE) begin
            last_d = owner_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign pick = (req0_i && req1_i) ? ~last_q : ~req0_i;
`else
    // Port 1 is chosen only when port 0 is not requesting.
    assign pick = ~req0_i;
`endif

    assign win_we    = pick ? we1_i    : we0_i;
    assign win_index = pick ? index1_i : index0_i;
    assign win_din   = pick ? din1_i   : din0_i;

    // For a depth smaller than the index space, writes beyond the array are
    // dropped so they cannot alias onto real entries.
    generate
        if (NUM_OF_ENTRY < (1 << ENTRY_WIDTH)) begin : g_partial_depth
            assign win_in_range = ({{(32-ENTRY_WIDTH){1'b0}}, win_index} < NUM_OF_ENTRY);
        end else begin : g_full_depth
            assign win_in_range = 1'b1;
        end
    endgenerate

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        cb_we_d  = cb_we_q;
        index_d  = index_q;
        din_d    = din_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                cb_we_d = 1'b0;
                if (req0_i || req1_i) begin
                    owner_d = pick;
                    wr_d    = win_we;
                    index_d = win_index;
                    din_d   = win_din;
                    cb_we_d = win_we && win_in_range;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // The array read is combinational, so cb_dout_i is valid for
                // the latched index throughout this cycle.
                cb_we_d = 1'b0;
                if (!wr_q) begin
                    if (owner_q) begin
                        rdata1_d = cb_dout_i;
                    end else begin
                        rdata0_d = cb_dout_i;
                    end
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                cb_we_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                cb_we_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            wr_q     <= 1'b0;
            cb_we_q  <= 1'b0;
            index_q  <= '0;
            din_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            cb_we_q  <= cb_we_d;
            index_q  <= index_d;
            din_q    <= din_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Grant and done are decoded from registered state only, so reset
    // removes them immediately.
    assign gnt0_o  = (state_q != ST_IDLE) && !owner_q;
    assign gnt1_o  = (state_q != ST_IDLE) &&  owner_q;
    assign done0_o = (state_q == ST_DONE) && !owner_q;
    assign done1_o = (state_q == ST_DONE) &&  owner_q;

    assign rdata0_o   = rdata0_q;
    assign rdata1_o   = rdata1_q;
    assign cb_index_o = index_q;
    assign cb_we_o    = cb_we_q;
    assign cb_din_o   = din_q;

endmodule

// File: tb/tb_cache_block_arbiter.sv
module tb_cache_block_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [9:0]  index0, index1;
    logic [31:0] din0, din1;
    logic        gnt0, gnt1, done0, done1;
    logic [31:0] rdata0, rdata1;
    logic [9:0]  cb_index;
    logic        cb_we;
    logic [31:0] cb_din;
    logic [31:0] cb_dout;

    int checks   = 0;
    int failures = 0;

    // Behavioural cache_block: synchronous write, combinational read.
    logic [31:0] mem [0:1023];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] <= 32'hA500_0000 | i;
        end
    end

    always @(posedge clk) begin
        if (cb_we) begin
            mem[cb_index] <= cb_din;
        end
    end

    assign cb_dout = mem[cb_index];

    cache_block_arbiter dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req0_i     (req0),
        .req1_i     (req1),
        .we0_i      (we0),
        .we1_i      (we1),
        .index0_i   (index0),
        .index1_i   (index1),
        .din0_i     (din0),
        .din1_i     (din1),
        .gnt0_o     (gnt0),
        .gnt1_o     (gnt1),
        .done0_o    (done0),
        .done1_o    (done1),
        .rdata0_o   (rdata0),
        .rdata1_o   (rdata1),
        .cb_index_o (cb_index),
        .cb_we_o    (cb_we),
        .cb_din_o   (cb_din),
        .cb_dout_i  (cb_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        index0 = 10'd0; index1 = 10'd0; din0 = 32'h0; din1 = 32'h0;
        tick();
        tick();
        checks++; if ({gnt0, gnt1, done0, done1, cb_we} !== 5'b0) begin failures++;
            $display("FAIL reset_ctrl: got %b expected %b", {gnt0, gnt1, done0, done1, cb_we}, 5'b0); end
        checks++; if (cb_index !== 10'd0) begin failures++;
            $display("FAIL reset_cb_index: got %h expected %h", cb_index, 10'd0); end
        checks++; if (cb_din !== 32'h0) begin failures++;
            $display("FAIL reset_cb_din: got %h expected %h", cb_din, 32'h0); end
        checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin failures++;
            $display("FAIL reset_rdata: got %h/%h expected 0/0", rdata0, rdata1); end
        rst = 1'b0;
        tick();
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin failures++;
            $display("FAIL release_gnt: got gnt0=%b gnt1=%b expected 1/0", gnt0, gnt1); end
        req0 = 1'b0;
        tick();
        checks++; if (done0 !== 1'b1 || rdata0 !== 32'hA500_0000) begin failures++;
            $display("FAIL release_read: got done0=%b rdata0=%h expected 1/a5000000", done0, rdata0); end
        tick();
        $display("txn reset-release read port0 index 0 rdata0=%h", rdata0);
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; index0 = 10'h002; din0 = 32'h0000_0FF0;
        tick();
        checks++; if (cb_we !== 1'b1 || cb_index !== 10'h002 || cb_din !== 32'h0FF0) begin failures++;
            $display("FAIL wr_access: got we=%b idx=%h din=%h expected 1/002/00000ff0", cb_we, cb_index, cb_din); end
        checks++; if (done0 !== 1'b0 || gnt0 !== 1'b1) begin failures++;
            $display("FAIL wr_access_gnt: got done0=%b gnt0=%b expected 0/1", done0, gnt0); end
        req0 = 1'b0;
        tick();
        checks++; if (cb_we !== 1'b0 || done0 !== 1'b1) begin failures++;
            $display("FAIL wr_done: got we=%b done0=%b expected 0/1", cb_we, done0); end
        checks++; if (rdata0 !== 32'hA500_0000) begin failures++;
            $display("FAIL wr_rdata_hold: got %h expected %h", rdata0, 32'hA500_0000); end
        tick();
        checks++; if (done0 !== 1'b0 || gnt0 !== 1'b0 || cb_index !== 10'h002) begin failures++;
            $display("FAIL wr_idle: got done0=%b gnt0=%b idx=%h expected 0/0/002", done0, gnt0, cb_index); end
        $display("txn write port0 index 002 data 00000ff0");
        req0 = 1'b1; we0 = 1'b0; index0 = 10'h002;
        tick();
        checks++; if (cb_we !== 1'b0 || cb_index !== 10'h002) begin failures++;
            $display("FAIL rd_access: got we=%b idx=%h expected 0/002", cb_we, cb_index); end
        req0 = 1'b0;
        tick();
        checks++; if (done0 !== 1'b1 || rdata0 !== 32'h0000_0FF0) begin failures++;
            $display("FAIL rd_after_wr: got done0=%b rdata0=%h expected 1/00000ff0", done0, rdata0); end
        tick();
        $display("txn read port0 index 002 rdata0=%h", rdata0);
    endtask

    task automatic test_tie();
        int t, ph, own;
        logic eg0, eg1, ed0, ed1;
        logic rr;
`ifdef CACHE_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        // Return the pointer to its reset value so the first tie goes to port 0.
        rst = 1'b1; #2; rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; index0 = 10'd4;
        req1 = 1'b1; we1 = 1'b0; index1 = 10'd6;
        for (int k = 1; k <= 12; k++) begin
            tick();
            t   = (k - 1) / 3;
            ph  = (k - 1) % 3;
            own = rr ? (t % 2) : 0;
            eg0 = (ph != 2) && (own == 0);
            eg1 = (ph != 2) && (own == 1);
            ed0 = (ph == 1) && (own == 0);
            ed1 = (ph == 1) && (own == 1);
            checks++; if (gnt0 !== eg0 || gnt1 !== eg1) begin failures++;
                $display("FAIL tie_gnt cycle %0d: got %b%b expected %b%b", k, gnt0, gnt1, eg0, eg1); end
            checks++; if (done0 !== ed0 || done1 !== ed1) begin failures++;
                $display("FAIL tie_done cycle %0d: got %b%b expected %b%b", k, done0, done1, ed0, ed1); end
            if (ed0) begin
                checks++; if (rdata0 !== 32'hA500_0004) begin failures++;
                    $display("FAIL tie_rdata0 cycle %0d: got %h expected a5000004", k, rdata0); end
                $display("txn tie read port0 index 4 rdata0=%h", rdata0);
            end
            if (ed1) begin
                checks++; if (rdata1 !== 32'hA500_0006) begin failures++;
                    $display("FAIL tie_rdata1 cycle %0d: got %h expected a5000006", k, rdata1); end
                $display("txn tie read port1 index 6 rdata1=%h", rdata1);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin failures++;
            $display("FAIL tie_quiet: got %b%b expected 00", gnt0, gnt1); end
    endtask

    task automatic test_abort();
        int dones;
        req0 = 1'b1; we0 = 1'b1; index0 = 10'd6; din0 = 32'h0000_DEAD;
        tick();
        checks++; if (cb_we !== 1'b1 || cb_index !== 10'd6) begin failures++;
            $display("FAIL abort_access: got we=%b idx=%h expected 1/006", cb_we, cb_index); end
        req0 = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (cb_we !== 1'b0 || gnt0 !== 1'b0) begin failures++;
            $display("FAIL abort_async: got we=%b gnt0=%b expected 0/0", cb_we, gnt0); end
        #1 rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done0 || done1) dones++;
        end
        checks++; if (dones !== 0) begin failures++;
            $display("FAIL abort_no_done: got %0d done cycles expected 0", dones); end
        $display("txn aborted write port0 index 6 data 0000dead");
        req0 = 1'b1; we0 = 1'b0; index0 = 10'd6;
        tick();
        req0 = 1'b0;
        tick();
        checks++; if (done0 !== 1'b1 || rdata0 !== 32'hA500_0006) begin failures++;
            $display("FAIL abort_readback: got done0=%b rdata0=%h expected 1/a5000006", done0, rdata0); end
        tick();
        $display("txn read port0 index 6 rdata0=%h", rdata0);
    endtask

    task automatic test_input_change();
        int dones;
        req1 = 1'b1; we1 = 1'b0; index1 = 10'd8;
        tick();
        checks++; if (gnt1 !== 1'b1 || cb_index !== 10'd8) begin failures++;
            $display("FAIL chg_access: got gnt1=%b idx=%h expected 1/008", gnt1, cb_index); end
        req1 = 1'b0; index1 = 10'd9;
        dones = 0;
        tick();
        if (done1) dones++;
        checks++; if (rdata1 !== 32'hA500_0008 || cb_index !== 10'd8) begin failures++;
            $display("FAIL chg_latched: got rdata1=%h idx=%h expected a5000008/008", rdata1, cb_index); end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done1) dones++;
        end
        checks++; if (dones !== 1) begin failures++;
            $display("FAIL chg_done_count: got %0d expected 1", dones); end
        checks++; if (gnt1 !== 1'b0 || gnt0 !== 1'b0) begin failures++;
            $display("FAIL chg_no_new_txn: got %b%b expected 00", gnt0, gnt1); end
        $display("txn read port1 index 8 rdata1=%h", rdata1);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_abort();
        test_input_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
